adder_result_buffer: RTL and testbench
======================================

Name: adder_result_buffer

Overview:
Downstream stage of the pipelined adder core.
- Captures every valid sum the core emits.
- Buffers sums in a FWFT FIFO and presents them to a ready/valid consumer.
- The core has no stall input, so the block also runs credit accounting: it tells the issuer when another operation may enter the core without risking FIFO overflow.

Parameters:
- WIDTH, 32, sum width; must equal the core's WIDTH.
- DEPTH, 8, FIFO entries; power of 2, ≥ LATENCY+1 for full throughput.
- LATENCY, 3, core latency from v_in to v_out in cycles.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- issue_ready  out  1  a new operation may be issued to the core this cycle.
- issue_fire  in  1  the core's v_in this cycle; one operation entered.
- res_valid  in  1  the core's v_out.
- res_sum  in  WIDTH  the core's sum.
- m_valid  out  1  buffered result available.
- m_ready  in  1  consumer accepts the result.
- m_sum  out  WIDTH  head-of-FIFO result.
- occupancy  out  clog2(DEPTH)+1  entries currently stored.
- err_overflow  out  1  sticky; a result was dropped because the FIFO was full.
- err_credit  out  1  sticky; issue_fire was asserted while issue_ready=0.
- perf_results  out  32  results delivered (only with the optional feature, else 0).
- perf_stalls  out  32  cycles with m_valid & !m_ready (only with the optional feature, else 0).

Behaviour:
- Reset (async assert):
  - Pointers, occupancy and in_flight go to 0.
  - m_valid=0, issue_ready=1, both err flags 0, perf counters 0.
  - m_sum is don't-care while m_valid=0.
- in_flight counter:
  - Range 0..DEPTH; +1 on issue_fire, -1 on res_valid.
  - Both asserted in the same cycle: no change.
  - Decrement at 0 holds at 0. This covers results still draining from the core after a mid-operation reset; such results are still stored if there is room.
- issue_ready = (occupancy + in_flight) < DEPTH. Combinational from registers only; no dependency on issue_fire.
- Write: res_valid with occupancy<DEPTH writes res_sum at wr_ptr.
- Overflow: res_valid with occupancy=DEPTH and no same-cycle pop drops the result and sets err_overflow.
- Full with simultaneous pop: the write is accepted.
- Read (FWFT):
  - m_valid = (occupancy != 0); m_sum = mem[rd_ptr].
  - A pop occurs when m_valid & m_ready.
- Latency: a result written at edge N is visible on m_valid/m_sum after edge N, i.e. one cycle after res_valid. No bypass when empty.
- Simultaneous push and pop: occupancy unchanged; both pointers advance.
- Pointer wrap: pointers are clog2(DEPTH) bits and wrap naturally. occupancy is tracked separately, so full and empty are unambiguous.
- Credit violation: issue_fire with issue_ready=0 sets err_credit; in_flight still increments (saturating at DEPTH).
- Sticky flags clear only on rst.
- Ordering: results leave in arrival order; the core preserves issue order.

Optional Feature:
- Macro: ADDER_RB_PERF_EN.
- Defined:
  - perf_results increments on each pop.
  - perf_stalls increments each cycle with m_valid & !m_ready.
  - Both are 32-bit, wrap at 2^32-1 → 0, and reset to 0.
- Undefined: both ports tied to 0; no counter flops are synthesised.

Decomposition:
- Shared package adder_pkg holds:
  - ADDER_WIDTH (32)
  - ADDER_LATENCY (3), shared with the core's instantiation
  - a clog2 constant function
- One natural sub-module: rb_fifo, a single-clock FWFT FIFO (mem, pointers, occupancy, push/pop with full/empty).
- The credit counter, error flags and perf counters stay in adder_result_buffer.

Test Plan (WIDTH=32, DEPTH=8, LATENCY=3):
- Reset, then single issue; res_valid with res_sum=0x0000_0005 three cycles later, m_ready=1.
  - Required: m_valid=1 for one cycle, one cycle after res_valid, with m_sum=0x0000_0005; occupancy returns to 0.
- m_ready=0, issue_fire held high while issue_ready=1.
  - Required: exactly 8 issues accepted; issue_ready drops after the 8th; occupancy=8 after the drain; err flags stay 0.
- Full FIFO, m_ready=1 and res_valid in the same cycle.
  - Required: push accepted; occupancy stays 8; err_overflow=0.
- Full FIFO, m_ready=0, forced res_valid=1 with 0xDEAD_BEEF.
  - Required: err_overflow=1; the value is absent from the output stream; occupancy=8.
- issue_fire asserted while issue_ready=0.
  - Required: err_credit=1 and remains set until rst.
- Assert rst with 5 entries stored and 2 operations in flight, then two stray res_valid.
  - Required: occupancy=0 immediately on reset; the strays are stored (occupancy=2); in_flight stays 0.
- With ADDER_RB_PERF_EN defined: 10 pops and 4 stall cycles.
  - Required: perf_results=10, perf_stalls=4.
  - Without the macro, both read 0.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared constants and helpers for the pipelined adder and its result buffer.
package adder_pkg;

  localparam int ADDER_WIDTH   = 32;
  localparam int ADDER_LATENCY = 3;

  // Ceiling log2 for elaboration-time sizing; clog2(1) is 0.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage : adder_pkg

// File: rtl/adder_result_buffer_if.sv
// Issue-credit, core-result and consumer handshake signals of the adder result buffer.
// slave is the buffer's view; master is the view of the issuer, core and consumer.
interface adder_result_buffer_if #(
  parameter int WIDTH = 32
);

  logic             issue_ready;
  logic             issue_fire;
  logic             res_valid;
  logic [WIDTH-1:0] res_sum;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_sum;

  modport slave (
    output issue_ready,
    input  issue_fire,
    input  res_valid,
    input  res_sum,
    output m_valid,
    input  m_ready,
    output m_sum
  );

  modport master (
    input  issue_ready,
    output issue_fire,
    output res_valid,
    output res_sum,
    input  m_valid,
    output m_ready,
    input  m_sum
  );

endinterface : adder_result_buffer_if

// File: rtl/adder_result_buffer_rb_fifo.sv
// Single-clock first-word-fall-through FIFO with explicit occupancy tracking.
// A push into a full FIFO is accepted only if a pop happens in the same cycle.
module rb_fifo
  import adder_pkg::*;
#(
  parameter  int WIDTH = ADDER_WIDTH,
  parameter  int DEPTH = 8,
  localparam int AW    = clog2(DEPTH),
  localparam int OW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             empty_o,
  output logic             push_drop_o,
  output logic [OW-1:0]    occupancy_o
);

  localparam logic [OW-1:0] DEPTH_C = OW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]    occ_q, occ_d;
  logic             full;
  logic             pop_acc;
  logic             push_acc;

  assign full        = (occ_q == DEPTH_C);
  assign empty_o     = (occ_q == '0);
  assign pop_acc     = pop_i && !empty_o;
  assign push_acc    = push_i && (!full || pop_acc);
  assign push_drop_o = push_i && !push_acc;
  assign head_o      = mem_q[rd_ptr_q];
  assign occupancy_o = occ_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push_acc) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop_acc) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push_acc, pop_acc})
      2'b10:   occ_d = occ_q + OW'(1);
      2'b01:   occ_d = occ_q - OW'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Storage is not reset; only slots below occupancy are ever presented.
  always_ff @(posedge clk) begin
    if (push_acc) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule : rb_fifo

// File: rtl/adder_result_buffer.sv
// Result buffer behind the pipelined adder: FWFT storage, issue credits, sticky errors.
// Define ADDER_RB_PERF_EN to build the delivered-result and stall counters.
module adder_result_buffer
  import adder_pkg::*;
#(
  parameter  int WIDTH   = ADDER_WIDTH,
  parameter  int DEPTH   = 8,
  parameter  int LATENCY = ADDER_LATENCY,
  localparam int OW      = clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  adder_result_buffer_if.slave  bus,
  output logic [OW-1:0]         occupancy_o,
  output logic                  err_overflow_o,
  output logic                  err_credit_o,
  output logic [31:0]           perf_results_o,
  output logic [31:0]           perf_stalls_o
);

  localparam logic [OW-1:0] DEPTH_C = OW'(DEPTH);

  if ((1 << clog2(DEPTH)) != DEPTH) begin : g_depth_pow2_check
    $error("adder_result_buffer: DEPTH must be a power of two");
  end
  if (DEPTH < LATENCY + 1) begin : g_depth_latency_check
    $error("adder_result_buffer: DEPTH below LATENCY+1 cannot sustain full issue rate");
  end

  logic [OW-1:0]    in_flight_q, in_flight_d;
  logic             err_overflow_q, err_overflow_d;
  logic             err_credit_q, err_credit_d;
  logic [OW:0]      credit_used;
  logic [OW-1:0]    occupancy;
  logic [WIDTH-1:0] head;
  logic             empty;
  logic             push_drop;
  logic             pop;

  rb_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (bus.res_valid),
    .push_data_i (bus.res_sum),
    .pop_i       (bus.m_ready),
    .head_o      (head),
    .empty_o     (empty),
    .push_drop_o (push_drop),
    .occupancy_o (occupancy)
  );

  assign bus.m_valid = !empty;
  assign bus.m_sum   = head;
  assign pop         = !empty && bus.m_ready;
  assign occupancy_o = occupancy;

  // Every stored result plus every operation still inside the core holds one slot.
  assign credit_used     = {1'b0, occupancy} + {1'b0, in_flight_q};
  assign bus.issue_ready = (credit_used < {1'b0, DEPTH_C});

  always_comb begin
    in_flight_d    = in_flight_q;
    err_overflow_d = err_overflow_q;
    err_credit_d   = err_credit_q;
    if (bus.issue_fire && !bus.res_valid) begin
      if (in_flight_q != DEPTH_C) begin
        in_flight_d = in_flight_q + OW'(1);
      end
    end else if (!bus.issue_fire && bus.res_valid) begin
      // Results left over from before a reset must not underflow the count.
      if (in_flight_q != '0) begin
        in_flight_d = in_flight_q - OW'(1);
      end
    end
    if (push_drop) begin
      err_overflow_d = 1'b1;
    end
    if (bus.issue_fire && !bus.issue_ready) begin
      err_credit_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_flight_q    <= '0;
      err_overflow_q <= 1'b0;
      err_credit_q   <= 1'b0;
    end else begin
      in_flight_q    <= in_flight_d;
      err_overflow_q <= err_overflow_d;
      err_credit_q   <= err_credit_d;
    end
  end

  assign err_overflow_o = err_overflow_q;
  assign err_credit_o   = err_credit_q;

`ifdef ADDER_RB_PERF_EN
  logic [31:0] perf_results_q, perf_results_d;
  logic [31:0] perf_stalls_q, perf_stalls_d;

  always_comb begin
    perf_results_d = perf_results_q;
    perf_stalls_d  = perf_stalls_q;
    if (pop) begin
      perf_results_d = perf_results_q + 32'd1;
    end
    if (!empty && !bus.m_ready) begin
      perf_stalls_d = perf_stalls_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_results_q <= '0;
      perf_stalls_q  <= '0;
    end else begin
      perf_results_q <= perf_results_d;
      perf_stalls_q  <= perf_stalls_d;
    end
  end

  assign perf_results_o = perf_results_q;
  assign perf_stalls_o  = perf_stalls_q;
`else
  logic unused_pop;
  assign unused_pop     = pop;
  assign perf_results_o = '0;
  assign perf_stalls_o  = '0;
`endif

endmodule : adder_result_buffer

// File: tb/tb_adder_result_buffer.sv
// Self-checking bench for adder_result_buffer: queue-based reference model, LATENCY-deep core stand-in.
module tb_adder_result_buffer;

  localparam int DEPTH = 8;
`ifdef ADDER_RB_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [3:0]  occupancy;
  logic        err_overflow;
  logic        err_credit;
  logic [31:0] perf_results;
  logic [31:0] perf_stalls;

  adder_result_buffer_if #(.WIDTH(32)) bus ();

  adder_result_buffer #(.WIDTH(32), .DEPTH(DEPTH), .LATENCY(3)) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .occupancy_o    (occupancy),
    .err_overflow_o (err_overflow),
    .err_credit_o   (err_credit),
    .perf_results_o (perf_results),
    .perf_stalls_o  (perf_stalls)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: stored results in arrival order plus credit bookkeeping.
  logic [31:0] mq[$];
  int          m_infl;
  bit          m_eov, m_ecr;
  int          m_pres, m_pstl;
  bit          core_en;
  bit          pv[3];
  logic [31:0] pd[3];

  function automatic bit model_ready();
    return (mq.size() + m_infl) < DEPTH;
  endfunction

  task automatic model_clear();
    mq.delete();
    m_infl = 0; m_eov = 0; m_ecr = 0; m_pres = 0; m_pstl = 0;
    for (int i = 0; i < 3; i++) begin pv[i] = 0; pd[i] = '0; end
  endtask

  task automatic step();
    bit mv, pp, rdy;
    @(posedge clk);
    mv  = mq.size() != 0;
    pp  = mv && bus.m_ready;
    rdy = model_ready();
    if (bus.issue_fire && !rdy) m_ecr = 1;
    if (pp) m_pres++;
    if (mv && !bus.m_ready) m_pstl++;
    if (pp) void'(mq.pop_front());
    if (bus.res_valid) begin
      if (mq.size() < DEPTH) mq.push_back(bus.res_sum);
      else m_eov = 1;
    end
    if (bus.issue_fire && !bus.res_valid) m_infl = (m_infl < DEPTH) ? m_infl + 1 : DEPTH;
    else if (!bus.issue_fire && bus.res_valid) m_infl = (m_infl > 0) ? m_infl - 1 : 0;
    if (core_en) begin
      pv[2] = pv[1]; pd[2] = pd[1];
      pv[1] = pv[0]; pd[1] = pd[0];
      pv[0] = bus.issue_fire; pd[0] = $urandom;
    end
    @(negedge clk);
    if (core_en) begin
      bus.res_valid = pv[2];
      bus.res_sum   = pd[2];
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_clear();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic idle_inputs();
    bus.issue_fire = 0; bus.res_valid = 0; bus.res_sum = '0; bus.m_ready = 0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (occupancy !== 4'd0) begin miscompares++; $display("FAIL reset_occ got %0d want 0", occupancy); end
    vectors++; if (bus.m_valid !== 1'b0) begin miscompares++; $display("FAIL reset_m_valid got %b want 0", bus.m_valid); end
    vectors++; if (bus.issue_ready !== 1'b1) begin miscompares++; $display("FAIL reset_issue_ready got %b want 1", bus.issue_ready); end
    vectors++; if ({err_overflow, err_credit} !== 2'b00) begin miscompares++; $display("FAIL reset_errs got %b%b want 00", err_overflow, err_credit); end
    vectors++; if (perf_results !== 32'd0 || perf_stalls !== 32'd0) begin miscompares++; $display("FAIL reset_perf got %0d/%0d want 0/0", perf_results, perf_stalls); end
  endtask

  task automatic test_single();
    bus.m_ready = 1;
    bus.issue_fire = 1; step(); bus.issue_fire = 0;
    step(); step();
    bus.res_valid = 1; bus.res_sum = 32'h0000_0005;
    vectors++; if (bus.m_valid !== 1'b0) begin miscompares++; $display("FAIL single_no_bypass got m_valid=%b want 0", bus.m_valid); end
    step();
    bus.res_valid = 0;
    vectors++; if (bus.m_valid !== 1'b1) begin miscompares++; $display("FAIL single_valid got %b want 1", bus.m_valid); end
    vectors++; if (bus.m_sum !== 32'h0000_0005) begin miscompares++; $display("FAIL single_sum got %h want 00000005", bus.m_sum); end
    step();
    vectors++; if (bus.m_valid !== 1'b0 || int'(occupancy) !== 0) begin miscompares++; $display("FAIL single_drain got m_valid=%b occ=%0d want 0/0", bus.m_valid, occupancy); end
    bus.m_ready = 0;
  endtask

  task automatic test_fill();
    int fires = 0;
    bus.m_ready = 0;
    core_en = 1;
    for (int c = 0; c < 20; c++) begin
      vectors++; if (bus.issue_ready !== model_ready()) begin miscompares++; $display("FAIL fill_issue_ready cyc %0d got %b want %b", c, bus.issue_ready, model_ready()); end
      bus.issue_fire = bus.issue_ready;
      if (bus.issue_ready) fires++;
      step();
    end
    bus.issue_fire = 0;
    core_en = 0;
    bus.res_valid = 0;
    vectors++; if (fires !== DEPTH) begin miscompares++; $display("FAIL fill_accepted got %0d want %0d", fires, DEPTH); end
    vectors++; if (int'(occupancy) !== 8 || bus.issue_ready !== 1'b0) begin miscompares++; $display("FAIL fill_full got occ=%0d rdy=%b want 8/0", occupancy, bus.issue_ready); end
    vectors++; if ({err_overflow, err_credit} !== 2'b00) begin miscompares++; $display("FAIL fill_errs got %b%b want 00", err_overflow, err_credit); end
  endtask

  task automatic test_full_push_pop();
    bus.m_ready = 1; bus.res_valid = 1; bus.res_sum = $urandom;
    step();
    bus.m_ready = 0; bus.res_valid = 0;
    vectors++; if (int'(occupancy) !== 8 || err_overflow !== 1'b0) begin miscompares++; $display("FAIL full_pushpop got occ=%0d ovf=%b want 8/0", occupancy, err_overflow); end
    vectors++; if (bus.m_sum !== mq[0]) begin miscompares++; $display("FAIL full_pushpop_head got %h want %h", bus.m_sum, mq[0]); end
  endtask

  task automatic test_overflow();
    bus.res_valid = 1; bus.res_sum = 32'hDEAD_BEEF;
    step();
    bus.res_valid = 0;
    vectors++; if (err_overflow !== 1'b1 || m_eov !== 1'b1) begin miscompares++; $display("FAIL overflow_flag got %b want 1", err_overflow); end
    vectors++; if (int'(occupancy) !== 8) begin miscompares++; $display("FAIL overflow_occ got %0d want 8", occupancy); end
  endtask

  task automatic test_credit();
    vectors++; if (bus.issue_ready !== 1'b0) begin miscompares++; $display("FAIL credit_pre_ready got %b want 0", bus.issue_ready); end
    bus.issue_fire = 1;
    step();
    bus.issue_fire = 0;
    vectors++; if (err_credit !== 1'b1) begin miscompares++; $display("FAIL credit_flag got %b want 1", err_credit); end
    bus.m_ready = 1;
    for (int i = 0; i < 8; i++) begin
      vectors++; if (bus.m_valid !== 1'b1 || bus.m_sum !== mq[0] || bus.m_sum === 32'hDEAD_BEEF) begin miscompares++; $display("FAIL drain_order pop %0d got v=%b %h want 1 %h", i, bus.m_valid, bus.m_sum, mq[0]); end
      step();
    end
    bus.m_ready = 0;
    vectors++; if (int'(occupancy) !== 0 || bus.m_valid !== 1'b0) begin miscompares++; $display("FAIL drain_empty got occ=%0d v=%b want 0/0", occupancy, bus.m_valid); end
    step(); step();
    vectors++; if (err_credit !== 1'b1 || err_overflow !== 1'b1) begin miscompares++; $display("FAIL sticky got ovf=%b cr=%b want 1/1", err_overflow, err_credit); end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    bus.m_ready = 0;
    bus.issue_fire = 1;
    step(); step();
    bus.res_valid = 1;
    for (int i = 0; i < 5; i++) begin bus.res_sum = $urandom; step(); end
    bus.issue_fire = 0; bus.res_valid = 0;
    vectors++; if (int'(occupancy) !== 5 || bus.issue_ready !== 1'b1) begin miscompares++; $display("FAIL midflight_setup got occ=%0d rdy=%b want 5/1", occupancy, bus.issue_ready); end
    #2 rst = 1;
    #1;
    vectors++; if (int'(occupancy) !== 0 || bus.m_valid !== 1'b0) begin miscompares++; $display("FAIL async_reset got occ=%0d v=%b want 0/0", occupancy, bus.m_valid); end
    model_clear();
    @(posedge clk); @(negedge clk);
    rst = 0;
    bus.res_valid = 1;
    for (int i = 0; i < 2; i++) begin bus.res_sum = 32'h1000_0000 + i; step(); end
    bus.res_valid = 0;
    vectors++; if (int'(occupancy) !== 2 || bus.m_sum !== 32'h1000_0000) begin miscompares++; $display("FAIL strays_stored got occ=%0d head=%h want 2 10000000", occupancy, bus.m_sum); end
    bus.issue_fire = 1;
    for (int i = 0; i < 6; i++) begin
      vectors++; if (bus.issue_ready !== 1'b1) begin miscompares++; $display("FAIL strays_inflight credit %0d got rdy=%b want 1", i, bus.issue_ready); end
      step();
    end
    bus.issue_fire = 0;
    vectors++; if (bus.issue_ready !== 1'b0) begin miscompares++; $display("FAIL strays_credit_limit got rdy=%b want 0", bus.issue_ready); end
  endtask

  task automatic test_random();
    do_reset();
    core_en = 1;
    for (int c = 0; c < 410; c++) begin
      if (c < 400) begin
        bus.issue_fire = model_ready() && ($urandom_range(0, 3) != 0);
        bus.m_ready    = ($urandom_range(0, 2) != 0);
      end else begin
        bus.issue_fire = 0;
        bus.m_ready    = 1;
      end
      vectors++; if (bus.issue_ready !== model_ready() || int'(occupancy) !== mq.size() || bus.m_valid !== (mq.size() != 0)) begin miscompares++; $display("FAIL random_ctrl cyc %0d got rdy=%b occ=%0d v=%b want %b %0d %b", c, bus.issue_ready, occupancy, bus.m_valid, model_ready(), mq.size(), mq.size() != 0); end
      if (mq.size() != 0) begin
        vectors++; if (bus.m_sum !== mq[0]) begin miscompares++; $display("FAIL random_sum cyc %0d got %h want %h", c, bus.m_sum, mq[0]); end
      end
      step();
    end
    core_en = 0; bus.res_valid = 0; bus.m_ready = 0;
    vectors++; if ({err_overflow, err_credit} !== {m_eov, m_ecr} || int'(occupancy) !== 0) begin miscompares++; $display("FAIL random_end got errs=%b%b occ=%0d want %b%b 0", err_overflow, err_credit, occupancy, m_eov, m_ecr); end
  endtask

  task automatic test_perf();
    do_reset();
    bus.m_ready = 0; bus.res_valid = 1;
    for (int i = 0; i < 4; i++) begin bus.res_sum = $urandom; step(); end
    bus.res_valid = 0;
    step();
    bus.m_ready = 1; bus.res_valid = 1;
    for (int i = 0; i < 6; i++) begin bus.res_sum = $urandom; step(); end
    bus.res_valid = 0;
    for (int i = 0; i < 4; i++) step();
    bus.m_ready = 0;
    vectors++; if (perf_results !== (PERF ? 32'd10 : 32'd0) || m_pres != 10) begin miscompares++; $display("FAIL perf_results got %0d want %0d", perf_results, PERF ? 10 : 0); end
    vectors++; if (perf_stalls !== (PERF ? 32'd4 : 32'd0) || m_pstl != 4) begin miscompares++; $display("FAIL perf_stalls got %0d want %0d", perf_stalls, PERF ? 4 : 0); end
    vectors++; if (int'(occupancy) !== 0) begin miscompares++; $display("FAIL perf_occ got %0d want 0", occupancy); end
  endtask

  initial begin
    rst = 1'b1;
    core_en = 0;
    idle_inputs();
    model_clear();
    @(negedge clk);
    test_reset();
    test_single();
    test_fill();
    test_full_push_pop();
    test_overflow();
    test_credit();
    test_reset_midflight();
    test_random();
    test_perf();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_adder_result_buffer
